// File: rtl/uart_rx_sampler_if.sv
// Receive-side handshake between uart_rx_sampler and the consuming core.
// The master side (the sampler) drives the held word and its status flags.
// The slave side (the core) returns the one-cycle rx_ack pulse.
interface uart_rx_sampler_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ack;
    logic                 frame_error;
    logic                 parity_error;
    logic                 overrun;

    modport master (
        output rx_data,
        output rx_valid,
        output frame_error,
        output parity_error,
        output overrun,
        input  rx_ack
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        input  frame_error,
        input  parity_error,
        input  overrun,
        output rx_ack
    );
endinterface

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: oversampled 8N1 (optionally 8E1) UART receiver front end.
// The sampling_clock level from the clock generator is edge-detected into
// one-cycle ticks. A small FSM centre-samples each bit, and completed frames
// land in a one-entry holding register with a valid/ack handshake.
// Optional feature macro: UART_RX_PARITY_EN adds an even-parity bit
// (11-bit frame). When it is undefined, parity_error is tied low.
module uart_rx_sampler #(
    parameter int OVERSAMPLE = 10,
    parameter int DATA_BITS  = 8
) (
    input  logic              physical_clock,
    input  logic              reset,
    input  logic              sampling_clock,
    input  logic              rx,
    output logic              busy,
    uart_rx_sampler_if.master rx_bus
);

    localparam int TICK_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int BIT_W  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [TICK_W-1:0] MID_TICK  = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    logic                 rx_meta_reg;
    logic                 rx_s_reg;
    logic                 sc_q_reg;
    logic                 tick_reg;

    state_t               state_reg;
    state_t               state_next;
    logic                 busy_reg;

    logic [TICK_W-1:0]    tick_cnt_reg;
    logic [BIT_W-1:0]     bit_cnt_reg;
    logic [DATA_BITS-1:0] shift_reg;
    logic [DATA_BITS-1:0] shift_next;

    logic                 mid_hit;
    logic                 last_hit;
    logic                 bit_last;

    // Strobes from the output decoder to the datapath
    logic                 cnt_clear;
    logic                 cnt_inc;
    logic                 bit_clear;
    logic                 bit_inc;
    logic                 shift_en;
    logic                 commit_en;

    logic [DATA_BITS-1:0] data_reg;
    logic                 valid_reg;
    logic                 frame_err_reg;
    logic                 overrun_reg;
    logic                 ack_hit;

`ifdef UART_RX_PARITY_EN
    logic                 par_cap;
    logic                 parity_bit_reg;
    logic                 parity_err_reg;
`endif

    assign mid_hit  = (tick_cnt_reg == MID_TICK);
    assign last_hit = (tick_cnt_reg == LAST_TICK);
    assign bit_last = (bit_cnt_reg == LAST_BIT);

    // An ack only means something while a word is actually held
    assign ack_hit  = rx_bus.rx_ack & valid_reg;

    // ------------------------------------------------------------------
    // Input conditioning
    // ------------------------------------------------------------------

    // Two-flop synchronizer for the asynchronous line; idles high out of reset
    always_ff @(posedge physical_clock or posedge reset) begin
        if (reset) begin
            rx_meta_reg <= 1'b1;
            rx_s_reg    <= 1'b1;
        end else begin
            rx_meta_reg <= rx;
            rx_s_reg    <= rx_meta_reg;
        end
    end

    // Rising-edge detect on sampling_clock, registered so the tick is one cycle wide
    always_ff @(posedge physical_clock or posedge reset) begin
        if (reset) begin
            sc_q_reg <= 1'b0;
            tick_reg <= 1'b0;
        end else begin
            sc_q_reg <= sampling_clock;
            tick_reg <= sampling_clock & ~sc_q_reg;
        end
    end

    // ------------------------------------------------------------------
    // Receive FSM
    // ------------------------------------------------------------------

    // State register; busy is registered from the next state so it tracks the FSM
    always_ff @(posedge physical_clock or posedge reset) begin
        if (reset) begin
            state_reg <= S_IDLE;
            busy_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            busy_reg  <= (state_next != S_IDLE);
        end
    end

    // Next-state decode; nothing moves between ticks, so a stalled time base freezes the FSM
    always_comb begin
        state_next = state_reg;
        if (tick_reg) begin
            case (state_reg)
                S_IDLE: begin
                    if (!rx_s_reg) begin
                        state_next = S_START;
                    end
                end
                S_START: begin
                    // Mid-start-bit recheck filters out short glitches
                    if (mid_hit) begin
                        state_next = rx_s_reg ? S_IDLE : S_DATA;
                    end
                end
                S_DATA: begin
                    if (last_hit && bit_last) begin
`ifdef UART_RX_PARITY_EN
                        state_next = S_PARITY;
`else
                        state_next = S_STOP;
`endif
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (last_hit) begin
                        state_next = S_STOP;
                    end
                end
`endif
                S_STOP: begin
                    if (last_hit) begin
                        state_next = S_IDLE;
                    end
                end
                default: state_next = S_IDLE;
            endcase
        end
    end

    // Output decode: per-tick strobes for the counters, shifter and holding register
    always_comb begin
        cnt_clear = 1'b0;
        cnt_inc   = 1'b0;
        bit_clear = 1'b0;
        bit_inc   = 1'b0;
        shift_en  = 1'b0;
        commit_en = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_cap   = 1'b0;
`endif
        if (tick_reg) begin
            case (state_reg)
                S_IDLE: begin
                    cnt_clear = 1'b1;
                end
                S_START: begin
                    if (mid_hit) begin
                        cnt_clear = 1'b1;
                        bit_clear = 1'b1;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
                S_DATA: begin
                    if (last_hit) begin
                        cnt_clear = 1'b1;
                        shift_en  = 1'b1;
                        bit_clear = bit_last;
                        bit_inc   = ~bit_last;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (last_hit) begin
                        cnt_clear = 1'b1;
                        par_cap   = 1'b1;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
`endif
                S_STOP: begin
                    if (last_hit) begin
                        cnt_clear = 1'b1;
                        commit_en = 1'b1;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
                default: begin
                    cnt_clear = 1'b1;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------

    // Tick counter within the current bit; only moves on tick cycles
    always_ff @(posedge physical_clock or posedge reset) begin
        if (reset) begin
            tick_cnt_reg <= '0;
        end else if (cnt_clear) begin
            tick_cnt_reg <= '0;
        end else if (cnt_inc) begin
            tick_cnt_reg <= tick_cnt_reg + TICK_W'(1);
        end
    end

    // Data bit index within the frame
    always_ff @(posedge physical_clock or posedge reset) begin
        if (reset) begin
            bit_cnt_reg <= '0;
        end else if (bit_clear) begin
            bit_cnt_reg <= '0;
        end else if (bit_inc) begin
            bit_cnt_reg <= bit_cnt_reg + BIT_W'(1);
        end
    end

    // LSB-first reception: each new bit enters at the MSB and walks down
    genvar gi;
    generate
        for (gi = 0; gi < DATA_BITS - 1; gi++) begin : g_shift
            assign shift_next[gi] = shift_reg[gi + 1];
        end
    endgenerate
    assign shift_next[DATA_BITS-1] = rx_s_reg;

    // Shift register load on each data-bit centre sample
    always_ff @(posedge physical_clock or posedge reset) begin
        if (reset) begin
            shift_reg <= '0;
        end else if (shift_en) begin
            shift_reg <= shift_next;
        end
    end

`ifdef UART_RX_PARITY_EN
    // Capture the received parity bit at its centre sample
    always_ff @(posedge physical_clock or posedge reset) begin
        if (reset) begin
            parity_bit_reg <= 1'b0;
        end else if (par_cap) begin
            parity_bit_reg <= rx_s_reg;
        end
    end
`endif

    // Holding register: an ack in the commit cycle frees the slot before the new word loads
    always_ff @(posedge physical_clock or posedge reset) begin
        if (reset) begin
            data_reg       <= '0;
            valid_reg      <= 1'b0;
            frame_err_reg  <= 1'b0;
            overrun_reg    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_reg <= 1'b0;
`endif
        end else if (commit_en) begin
            if (!valid_reg || ack_hit) begin
                data_reg       <= shift_reg;
                valid_reg      <= 1'b1;
                frame_err_reg  <= ~rx_s_reg;
                overrun_reg    <= 1'b0;
`ifdef UART_RX_PARITY_EN
                // Even parity: data bits plus parity bit must XOR to zero
                parity_err_reg <= (^shift_reg) ^ parity_bit_reg;
`endif
            end else begin
                // Slot still full: drop the new word and flag the loss
                overrun_reg <= 1'b1;
            end
        end else if (ack_hit) begin
            valid_reg      <= 1'b0;
            frame_err_reg  <= 1'b0;
            overrun_reg    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_reg <= 1'b0;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign busy               = busy_reg;
    assign rx_bus.rx_data     = data_reg;
    assign rx_bus.rx_valid    = valid_reg;
    assign rx_bus.frame_error = frame_err_reg;
    assign rx_bus.overrun     = overrun_reg;
`ifdef UART_RX_PARITY_EN
    assign rx_bus.parity_error = parity_err_reg;
`else
    assign rx_bus.parity_error = 1'b0;
`endif

endmodule
